// File: rtl/memaddr_seq.sv
// Memory address sequencer: grants data/prefetch references, steers the MA mux,
// splits longword-crossing data references and guards wait states with a watchdog.
module memaddr_seq #(
  parameter int TMO_CYCLES = 255,
  parameter int IB_STARVE  = 4
) (
  input  logic       b_clk_l,
  input  logic       reset_h,
  input  logic       dreq_h,
  input  logic       dcross_h,
  input  logic       ireq_h,
  input  logic       mem_done_h,
  input  logic       page_boundary_h,
  output logic [1:0] ma_select_h,
  output logic       latch_ma_l,
  output logic       ena_pc_l,
  output logic       ena_va_save_l,
  output logic       ddone_h,
  output logic       idone_h,
  output logic       xpage_h,
  output logic       tmo_h,
  output logic       busy_h
);

  typedef enum logic [2:0] {
    IDLE, D_ADDR, D_WAIT, X_ADDR, X_WAIT, I_ADDR, I_WAIT
  } state_e;

  localparam logic [2:0] STARVE_MAX = 3'(IB_STARVE);
  localparam logic [7:0] TMO_LIM    = 8'(TMO_CYCLES);

  state_e     state_q, state_d;
  logic [2:0] starve_q, starve_d;
  logic       cross_q, cross_d;
  logic [7:0] wdog_q, wdog_d;
  logic [1:0] sel_q, sel_d;
  logic       latch_q, latch_d;
  logic       pc_q, pc_d;
  logic       vas_q, vas_d;
  logic       ddone_q, ddone_d;
  logic       idone_q, idone_d;
  logic       xpage_q, xpage_d;
  logic       tmo_q, tmo_d;
  logic       busy_q, busy_d;

  logic       d_grant;
  logic       expire;
  logic [7:0] wdog_inc;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    cross_d  = cross_q;
    wdog_d   = wdog_q;
    ddone_d  = 1'b0;
    idone_d  = 1'b0;
    xpage_d  = 1'b0;
    tmo_d    = 1'b0;
    pc_d     = 1'b1;
    d_grant  = dreq_h &&
               !(ireq_h && starve_q == STARVE_MAX);
    wdog_inc = wdog_q + 8'd1;
    expire   = (wdog_inc == TMO_LIM);

    unique case (state_q)
      IDLE: begin
        if (d_grant) begin
          state_d = D_ADDR;
          cross_d = dcross_h;
          if (ireq_h && starve_q != STARVE_MAX)
            starve_d = starve_q + 3'd1;
        end else if (ireq_h) begin
          state_d  = I_ADDR;
          starve_d = 3'd0;
        end
      end
      D_ADDR: begin
        state_d = D_WAIT;
        wdog_d  = 8'd0;
      end
      X_ADDR: begin
        state_d = X_WAIT;
        wdog_d  = 8'd0;
      end
      I_ADDR: begin
        state_d = I_WAIT;
        wdog_d  = 8'd0;
      end
      D_WAIT: begin
        if (mem_done_h) begin
          if (!cross_q) begin
            state_d = IDLE;
            ddone_d = 1'b1;
          end else if (page_boundary_h) begin
            state_d = IDLE;
            xpage_d = 1'b1;
          end else begin
            state_d = X_ADDR;
          end
        end else if (expire) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      X_WAIT: begin
        if (mem_done_h) begin
          state_d = IDLE;
          ddone_d = 1'b1;
        end else if (expire) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      I_WAIT: begin
        if (mem_done_h) begin
          state_d = IDLE;
          idone_d = 1'b1;
          pc_d    = 1'b0;
        end else if (expire) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!ireq_h)
      starve_d = 3'd0;

    // Address-phase outputs follow the state being entered.
    sel_d   = 2'b11;
    latch_d = 1'b1;
    vas_d   = 1'b1;
    unique case (1'b1)
      (state_d == D_ADDR): begin
        sel_d   = 2'b00;
        latch_d = 1'b0;
        vas_d   = 1'b0;
      end
      (state_d == I_ADDR): begin
        sel_d   = 2'b01;
        latch_d = 1'b0;
      end
      (state_d == X_ADDR): begin
        sel_d   = 2'b10;
        latch_d = 1'b0;
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge b_clk_l) begin
    if (reset_h) begin
      state_q  <= IDLE;
      starve_q <= 3'd0;
      cross_q  <= 1'b0;
      wdog_q   <= 8'd0;
      sel_q    <= 2'b11;
      latch_q  <= 1'b1;
      pc_q     <= 1'b1;
      vas_q    <= 1'b1;
      ddone_q  <= 1'b0;
      idone_q  <= 1'b0;
      xpage_q  <= 1'b0;
      tmo_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      cross_q  <= cross_d;
      wdog_q   <= wdog_d;
      sel_q    <= sel_d;
      latch_q  <= latch_d;
      pc_q     <= pc_d;
      vas_q    <= vas_d;
      ddone_q  <= ddone_d;
      idone_q  <= idone_d;
      xpage_q  <= xpage_d;
      tmo_q    <= tmo_d;
      busy_q   <= busy_d;
    end
  end

  assign ma_select_h   = sel_q;
  assign latch_ma_l    = latch_q;
  assign ena_pc_l      = pc_q;
  assign ena_va_save_l = vas_q;
  assign ddone_h       = ddone_q;
  assign idone_h       = idone_q;
  assign xpage_h       = xpage_q;
  assign tmo_h         = tmo_q;
  assign busy_h        = busy_q;

endmodule

// File: tb/tb_memaddr_seq.sv
// Bench for memaddr_seq: directed vector table, starvation sequence,
// and randomized traffic against a reference-level model.
module tb_memaddr_seq;

  localparam int TMO = 5;
  localparam int IBS = 4;

  logic       clk = 1'b0;
  logic       reset_h = 1'b0;
  logic       dreq_h = 1'b0;
  logic       dcross_h = 1'b0;
  logic       ireq_h = 1'b0;
  logic       mem_done_h = 1'b0;
  logic       page_boundary_h = 1'b0;
  logic [1:0] ma_select_h;
  logic       latch_ma_l;
  logic       ena_pc_l;
  logic       ena_va_save_l;
  logic       ddone_h;
  logic       idone_h;
  logic       xpage_h;
  logic       tmo_h;
  logic       busy_h;

  memaddr_seq #(.TMO_CYCLES(TMO), .IB_STARVE(IBS)) dut (
    .b_clk_l         (clk),
    .reset_h         (reset_h),
    .dreq_h          (dreq_h),
    .dcross_h        (dcross_h),
    .ireq_h          (ireq_h),
    .mem_done_h      (mem_done_h),
    .page_boundary_h (page_boundary_h),
    .ma_select_h     (ma_select_h),
    .latch_ma_l      (latch_ma_l),
    .ena_pc_l        (ena_pc_l),
    .ena_va_save_l   (ena_va_save_l),
    .ddone_h         (ddone_h),
    .idone_h         (idone_h),
    .xpage_h         (xpage_h),
    .tmo_h           (tmo_h),
    .busy_h          (busy_h)
  );

  always #5 clk = ~clk;

  // inputs {rst,dreq,dcross,ireq,done,pb}
  localparam logic [5:0] I_RST  = 6'b100000;
  localparam logic [5:0] I_NONE = 6'b000000;
  localparam logic [5:0] I_D    = 6'b010000;
  localparam logic [5:0] I_DX   = 6'b011000;
  localparam logic [5:0] I_I    = 6'b000100;
  localparam logic [5:0] I_DONE = 6'b000010;
  localparam logic [5:0] I_DNPB = 6'b000011;
  // outputs {sel,latch,pc,vas,dd,id,xp,tmo,busy}
  localparam logic [9:0] O_IDLE = 10'b11_1_1_1_0_0_0_0_0;
  localparam logic [9:0] O_WAIT = 10'b11_1_1_1_0_0_0_0_1;
  localparam logic [9:0] O_DA   = 10'b00_0_1_0_0_0_0_0_1;
  localparam logic [9:0] O_XA   = 10'b10_0_1_1_0_0_0_0_1;
  localparam logic [9:0] O_IA   = 10'b01_0_1_1_0_0_0_0_1;
  localparam logic [9:0] O_DD   = 10'b11_1_1_1_1_0_0_0_0;
  localparam logic [9:0] O_ID   = 10'b11_1_0_1_0_1_0_0_0;
  localparam logic [9:0] O_XP   = 10'b11_1_1_1_0_0_1_0_0;
  localparam logic [9:0] O_TMO  = 10'b11_1_1_1_0_0_0_1_0;

  typedef struct {
    logic [5:0] in;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_run = 0;
  int   n_fail = 0;

  function automatic logic [9:0] outs();
    return {ma_select_h, latch_ma_l, ena_pc_l,
            ena_va_save_l, ddone_h, idone_h,
            xpage_h, tmo_h, busy_h};
  endfunction

  task automatic drive(input logic [5:0] v);
    {reset_h, dreq_h, dcross_h,
     ireq_h, mem_done_h, page_boundary_h} = v;
  endtask

  task automatic chk(input string nm,
                     input logic [9:0] got,
                     input logic [9:0] want);
    n_run++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%b want=%b", nm, got, want);
    end
  endtask

  task automatic add(input logic [5:0] i,
                     input logic [9:0] o);
    vec_t v;
    v.in  = i;
    v.exp = o;
    tbl.push_back(v);
  endtask

  // Reference model: phase 0 idle, 1 address, 2 wait.
  int   m_phase, m_wait, m_starve;
  bit   m_data, m_second, m_cross;
  logic [9:0] m_out;

  task automatic model_step(input logic [5:0] v);
    bit rst, dq, dx, iq, dn, pb;
    bit dd, id, xp, to;
    logic [1:0] sel;
    {rst, dq, dx, iq, dn, pb} = v;
    {dd, id, xp, to} = 4'b0;
    if (rst) begin
      m_phase = 0; m_starve = 0;
      m_cross = 0; m_wait = 0;
    end else begin
      case (m_phase)
        0: begin
          if (dq && !(iq && m_starve == IBS)) begin
            m_phase = 1; m_data = 1;
            m_second = 0; m_cross = dx;
            if (iq && m_starve < IBS) m_starve++;
          end else if (iq) begin
            m_phase = 1; m_data = 0;
            m_second = 0; m_starve = 0;
          end
        end
        1: begin
          m_phase = 2; m_wait = 0;
        end
        default: begin
          if (dn) begin
            if (!m_data) begin
              id = 1; m_phase = 0;
            end else if (m_second || !m_cross) begin
              dd = 1; m_phase = 0;
            end else if (pb) begin
              xp = 1; m_phase = 0;
            end else begin
              m_phase = 1; m_second = 1;
            end
          end else if (m_wait + 1 == TMO) begin
            to = 1; m_phase = 0;
          end else begin
            m_wait++;
          end
        end
      endcase
      if (!iq) m_starve = 0;
    end
    sel = 2'b11;
    if (m_phase == 1)
      sel = !m_data ? 2'b01 : (m_second ? 2'b10 : 2'b00);
    m_out = {sel, !(m_phase == 1), !id,
             !(m_phase == 1 && m_data && !m_second),
             dd, id, xp, to, m_phase != 0};
  endtask

  initial begin
    logic [1:0] gsel[$];
    int wt;

    add(I_RST, O_IDLE);
    add(I_D, O_DA);
    add(I_NONE, O_WAIT);
    add(I_NONE, O_WAIT);
    add(I_NONE, O_WAIT);
    add(I_DONE, O_DD);
    add(I_NONE, O_IDLE);
    add(I_DX, O_DA);
    add(I_NONE, O_WAIT);
    add(I_DONE, O_XA);
    add(I_NONE, O_WAIT);
    add(I_DONE, O_DD);
    add(I_NONE, O_IDLE);
    add(I_DX, O_DA);
    add(I_NONE, O_WAIT);
    add(I_DNPB, O_XP);
    add(I_NONE, O_IDLE);
    add(I_D, O_DA);
    for (int i = 0; i < 5; i++) add(I_NONE, O_WAIT);
    add(I_NONE, O_TMO);
    add(I_NONE, O_IDLE);
    add(I_D, O_DA);
    for (int i = 0; i < 5; i++) add(I_NONE, O_WAIT);
    add(I_DONE, O_DD);
    add(I_NONE, O_IDLE);
    add(I_I, O_IA);
    add(I_NONE, O_WAIT);
    add(I_DONE, O_ID);
    add(I_NONE, O_IDLE);
    add(I_DX, O_DA);
    add(I_NONE, O_WAIT);
    add(I_DONE, O_XA);
    add(I_NONE, O_WAIT);
    add(I_RST, O_IDLE);
    add(I_D, O_DA);
    add(I_NONE, O_WAIT);
    add(I_DONE, O_DD);
    add(I_NONE, O_IDLE);
    add(I_DONE, O_IDLE);
    add(I_D, O_DA);
    add(I_DONE, O_WAIT);
    add(I_NONE, O_WAIT);
    add(I_DONE, O_DD);
    add(I_NONE, O_IDLE);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].in);
      @(posedge clk); #1;
      chk($sformatf("vec[%0d]", i), outs(), tbl[i].exp);
    end

    // Both requests held: expect DDDDI repeating.
    drive(I_RST);
    @(posedge clk); #1;
    drive(6'b010100);
    wt = 0;
    for (int c = 0; c < 300 && gsel.size() < 10; c++) begin
      @(posedge clk); #1;
      mem_done_h = 1'b0;
      if (idone_h || !ena_pc_l)
        chk("pc_with_idone", {9'd0, ena_pc_l},
            {9'd0, ~idone_h});
      if (!latch_ma_l) begin
        gsel.push_back(ma_select_h);
        wt = 1;
      end else if (wt == 1) begin
        mem_done_h = 1'b1;
        wt = 0;
      end
    end
    chk("starve_cnt", 10'(gsel.size()), 10'd10);
    for (int i = 0; i < gsel.size(); i++)
      chk($sformatf("starve_grant[%0d]", i),
          {8'd0, gsel[i]},
          (i % 5 == 4) ? 10'd1 : 10'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [5:0] v;
      v[5] = (c == 0) || ($urandom_range(0, 99) == 0);
      v[4] = ($urandom_range(0, 2) != 0);
      v[3] = $urandom_range(0, 1) == 1;
      v[2] = ($urandom_range(0, 2) != 0);
      v[1] = ($urandom_range(0, 3) == 0);
      v[0] = $urandom_range(0, 1) == 1;
      drive(v);
      model_step(v);
      @(posedge clk); #1;
      chk($sformatf("rand[%0d]", c), outs(), m_out);
    end

    drive(I_NONE);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/memaddr_seq.md
MEMADDR_SEQ -- requirements
Module: memaddr_seq

Interface
REQ-001 Parameter TMO_CYCLES, default 255: wait-state watchdog limit, range 1..255.
REQ-002 Parameter IB_STARVE, default 4: consecutive data grants with a pending prefetch before the prefetch is forced.
REQ-003 b_clk_l  in  1  block clock; all state changes on its rising edge.
REQ-004 reset_h  in  1  synchronous, active-high reset.
REQ-005 dreq_h  in  1  microcode data reference request; level, held until ddone_h.
REQ-006 dcross_h  in  1  data reference spans a longword boundary; sampled with dreq_h at grant.
REQ-007 ireq_h  in  1  instruction prefetch request; level, held until idone_h.
REQ-008 mem_done_h  in  1  memory cycle complete, one-cycle pulse.
REQ-009 page_boundary_h  in  1  MA datapath at last longword of page.
REQ-010 ma_select_h  out  2  MA source: 00 VA, 01 PC, 10 VA+4, 11 hold.
REQ-011 latch_ma_l  out  1  active-low MA latch strobe.
REQ-012 ena_pc_l  out  1  active-low PC advance strobe.
REQ-013 ena_va_save_l  out  1  active-low VA save strobe.
REQ-014 ddone_h, idone_h  out  1 each  completion pulses.
REQ-015 xpage_h  out  1  cross-page trap pulse.
REQ-016 tmo_h  out  1  watchdog expiry pulse.
REQ-017 busy_h  out  1  high in any state other than IDLE.

Function
REQ-018 States: IDLE, D_ADDR, D_WAIT, X_ADDR, X_WAIT, I_ADDR, I_WAIT.
REQ-019 Grant in IDLE: dreq_h takes priority over ireq_h, except that ireq_h wins when starve_cnt = IB_STARVE.
REQ-020 starve_cnt (3 bit): increments on each data grant while ireq_h=1; clears on a prefetch grant or when ireq_h=0; saturates at IB_STARVE.
REQ-021 D_ADDR (1 cycle): ma_select_h=00, latch_ma_l=0, ena_va_save_l=0; dcross_h is captured into cross_pend; next state D_WAIT.
REQ-022 I_ADDR (1 cycle): ma_select_h=01, latch_ma_l=0; next state I_WAIT.
REQ-023 X_ADDR (1 cycle): ma_select_h=10, latch_ma_l=0; next state X_WAIT.
REQ-024 In all other cycles: ma_select_h=11 and every strobe inactive.
REQ-025 D_WAIT on mem_done_h: if cross_pend=0, pulse ddone_h and go to IDLE; if cross_pend=1 and page_boundary_h=1, pulse xpage_h (no ddone_h) and go to IDLE; otherwise go to X_ADDR.
REQ-026 X_WAIT on mem_done_h: pulse ddone_h and go to IDLE.
REQ-027 I_WAIT on mem_done_h: pulse idone_h and ena_pc_l=0 in the same cycle, then go to IDLE.
REQ-028 Pulse width: every done, trap and strobe output is exactly one cycle.
REQ-029 Request latency: a request seen in IDLE produces latch_ma_l in the next cycle; IDLE-to-ADDR takes 1 edge.
REQ-030 There is no back-to-back grant: at least one IDLE cycle follows every completion.
REQ-031 Watchdog (8 bit): cleared on entry to any WAIT state; increments each WAIT cycle without mem_done_h.
REQ-032 Watchdog expiry: when the count reaches TMO_CYCLES, pulse tmo_h and go to IDLE with no done pulse.
REQ-033 If mem_done_h coincides with watchdog expiry, mem_done_h wins and tmo_h is not asserted.
REQ-034 mem_done_h received in IDLE or any ADDR state is ignored.
REQ-035 Requests deasserted mid-reference do not abort the sequence.

Reset
REQ-036 reset_h=1 at an edge forces IDLE from any state, including mid-WAIT.
REQ-037 reset_h also clears starve_cnt, cross_pend and the watchdog.
REQ-038 Outputs from the first edge with reset_h=1: ma_select_h=11, latch_ma_l=ena_pc_l=ena_va_save_l=1, ddone_h=idone_h=xpage_h=tmo_h=busy_h=0.
REQ-039 A reference interrupted by reset produces no done pulse.

Verification
REQ-040 dreq_h=1, dcross_h=0; mem_done_h 3 cycles after latch -> latch_ma_l low with ma_select_h=00 and ena_va_save_l low, then ddone_h at that edge, busy_h low next cycle.
REQ-041 dreq_h=1, dcross_h=1, page_boundary_h=0 -> two latches, ma_select_h=00 then 10, and a single ddone_h; repeat with page_boundary_h=1 -> one latch then xpage_h, no ddone_h.
REQ-042 dreq_h and ireq_h held high continuously -> 4 data grants followed by 1 prefetch grant (ma_select_h=01, ena_pc_l pulse with idone_h), then the pattern repeats.
REQ-043 TMO_CYCLES=5, no mem_done_h -> tmo_h on the 5th WAIT cycle, IDLE next; mem_done_h on the same cycle -> ddone_h and no tmo_h.
REQ-044 reset_h pulsed during X_WAIT -> all outputs at reset values at the next edge; a following dreq_h restarts at D_ADDR with ma_select_h=00.
